// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction memory port between fetch (priority) and the loader.
// Define IMEM_ADDR_CHECK_EN to drop misaligned/out-of-range requests and raise a sticky err.
module imem_arbiter #(
  parameter int DEPTH_BYTES = 1024,
  parameter int MAX_WAIT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req_valid,
  input  logic [31:0] f_req_addr,
  output logic        f_req_ready,
  output logic        f_rsp_valid,
  output logic [31:0] f_rsp_data,
  input  logic        l_req_valid,
  input  logic        l_req_we,
  input  logic [31:0] l_req_addr,
  input  logic [31:0] l_req_wdata,
  input  logic        l_lock,
  output logic        l_req_ready,
  output logic        l_rsp_valid,
  output logic [31:0] l_rsp_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  typedef enum logic {SHARED, LOCKED} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOADER} owner_t;

  localparam logic [3:0]  MaxWait  = 4'(MAX_WAIT);
  localparam logic [31:0] LastWord = 32'(DEPTH_BYTES - 4);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_badMaxWait
    $error("imem_arbiter: MAX_WAIT must be in 1..15");
  end
  if (DEPTH_BYTES < 4) begin : g_badDepth
    $error("imem_arbiter: DEPTH_BYTES must be at least 4");
  end

  state_t      r_state;
  state_t      w_stateNext;
  owner_t      r_owner;
  logic [3:0]  r_waitCnt;
  logic        r_rspZero;
  logic        w_fGrant;
  logic        w_lGrant;
  logic        w_grant;
  logic        w_badAddr;
  logic        w_forward;
  logic [31:0] w_reqAddr;

  // A starved loader overrides fetch once it has waited MAX_WAIT cycles.
  always_comb begin
    w_fGrant    = 1'b0;
    w_lGrant    = 1'b0;
    w_stateNext = l_lock ? LOCKED : SHARED;
    if (r_state == LOCKED) begin
      w_lGrant = l_req_valid;
    end else if (l_req_valid && (r_waitCnt == MaxWait)) begin
      w_lGrant = 1'b1;
    end else if (f_req_valid) begin
      w_fGrant = 1'b1;
    end else if (l_req_valid) begin
      w_lGrant = 1'b1;
    end
  end

  assign w_grant   = w_fGrant | w_lGrant;
  assign w_reqAddr = w_lGrant ? l_req_addr : f_req_addr;

`ifdef IMEM_ADDR_CHECK_EN
  assign w_badAddr = (w_reqAddr[1:0] != 2'b00) || (w_reqAddr > LastWord);
`else
  assign w_badAddr = 1'b0;
`endif

  assign w_forward   = w_grant & ~w_badAddr;
  assign f_req_ready = w_fGrant;
  assign l_req_ready = w_lGrant;
  assign mem_en      = w_forward;
  assign mem_we      = w_forward & w_lGrant & l_req_we;
  assign mem_addr    = w_reqAddr;
  assign mem_wdata   = w_lGrant ? l_req_wdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SHARED;
      r_waitCnt <= 4'd0;
      r_owner   <= OWN_NONE;
      r_rspZero <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (!l_req_valid || w_lGrant) begin
        r_waitCnt <= 4'd0;
      end else if (r_waitCnt < MaxWait) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end
      if (w_fGrant) begin
        r_owner <= OWN_FETCH;
      end else if (w_lGrant) begin
        r_owner <= OWN_LOADER;
      end else begin
        r_owner <= OWN_NONE;
      end
      // Write acks and dropped requests answer with zero instead of memory data.
      r_rspZero <= (w_lGrant & l_req_we) | w_badAddr;
    end
  end

  assign f_rsp_valid = (r_owner == OWN_FETCH);
  assign l_rsp_valid = (r_owner == OWN_LOADER);
  assign f_rsp_data  = (f_rsp_valid && !r_rspZero) ? mem_rdata : 32'h0;
  assign l_rsp_data  = (l_rsp_valid && !r_rspZero) ? mem_rdata : 32'h0;

`ifdef IMEM_ADDR_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_grant && w_badAddr) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the single port of the byte-addressed, big-endian instruction memory between two requesters: the pipeline fetch stage and the program loader (boot/debug path that writes and reads back instruction words). Fetch has priority; a wait counter bounds loader starvation, and a loader lock grants the memory exclusively for burst program loads. Sits between the IF stage / loader and the instruction memory array, which returns read data one cycle after a read enable.

## Interface
- DEPTH_BYTES, 1024: instruction memory size in bytes.
- MAX_WAIT, 4: cycles a pending loader request may be refused before it wins over fetch (1..15).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req_valid / f_req_addr  in  1 / 32  fetch read request, byte address.
- f_req_ready  out  1  fetch request granted this cycle.
- f_rsp_valid / f_rsp_data  out  1 / 32  fetch read response.
- l_req_valid / l_req_we  in  1 / 1  loader request; we=1 write, we=0 read.
- l_req_addr / l_req_wdata  in  32 / 32  loader byte address, write word.
- l_lock  in  1  loader requests exclusive ownership.
- l_req_ready  out  1  loader request granted this cycle.
- l_rsp_valid / l_rsp_data  out  1 / 32  loader response (read data or write ack).
- mem_en / mem_we  out  1 / 1  memory access enable, write enable.
- mem_addr / mem_wdata  out  32 / 32  memory byte address, write word (big-endian byte order in memory).
- mem_rdata  in  32  memory read word, valid the cycle after mem_en=1, mem_we=0.
- err  out  1  sticky address error (see Configuration).

## Operation
- Transfer occurs when valid and ready are both high. At most one grant per cycle. Ready is combinational from valids, state and wait_cnt; requesters must not make valid depend on ready.
- States: SHARED (reset) and LOCKED.
  - SHARED to LOCKED: at the clock edge where l_lock=1.
  - LOCKED to SHARED: at the clock edge where l_lock=0.
- SHARED grant rule, in priority order:
  1. Loader valid and wait_cnt==MAX_WAIT: loader wins.
  2. Else fetch valid: fetch wins.
  3. Else loader valid: loader wins.
- LOCKED: f_req_ready=0; loader is granted whenever valid.
- wait_cnt (4 bits):
  - Increments when loader valid and not granted; saturates at MAX_WAIT.
  - Clears on loader grant or when l_req_valid=0.
- Granted request drives mem_en=1, mem_addr, mem_we (loader we; fetch always 0) and mem_wdata in the same cycle. With no grant: mem_en=0 and mem_we=0.
- owner register (NONE/FETCH/LOADER) is set on each grant and NONE otherwise.
- Next cycle, the owner gets rsp_valid=1:
  - Reads: rsp_data = mem_rdata.
  - Loader writes: l_rsp_data = 0 (ack).
  - Non-owner rsp_data is 0.
- A fetch read granted in the cycle l_lock rises still completes; its response is delivered in LOCKED.

## Timing
- Request to response: exactly 1 cycle, fully pipelined; back-to-back grants every cycle.
- Write is committed at the grant edge; readback of the same address in the next grant returns the new word.
- Reset (async, any time): state=SHARED, wait_cnt=0, owner=NONE, f_rsp_valid=0, l_rsp_valid=0, err=0. Combinational outputs follow: readies reflect SHARED, mem_en=0 when no valid. An in-flight response is dropped, not replayed.
- Loader can be starved at most MAX_WAIT consecutive cycles in SHARED.

## Configuration
- IMEM_ADDR_CHECK_EN defined:
  - A request with addr[1:0]!=0 or addr>DEPTH_BYTES-4 is granted by normal arbitration but not forwarded (mem_en=0).
  - Its response next cycle has rsp_valid=1 and data 32'h0000_0000.
  - err is set and held until reset.
- Undefined: addresses are forwarded unchanged, and err is tied 0.

## Test plan
- Fetch-only stream at 0,4,8,… with loader preloaded words: f_req_ready=1 every cycle; f_rsp_data matches the word one cycle later (addr 0 → 32'h21080000).
- Fetch valid continuously, loader write at addr 16 with MAX_WAIT=4: loader is granted on the 5th cycle; fetch is refused that cycle; l_rsp_valid pulses with data 0.
- l_lock=1 during fetch burst: the fetch grant in the l_lock-rise cycle still responds. Then f_req_ready=0 until l_lock falls. Loader write then readback of addr 0 with 32'hDEADBEEF returns 32'hDEADBEEF.
- Simultaneous fetch and loader valid, wait_cnt<MAX_WAIT: fetch is granted, wait_cnt increments; dropping l_req_valid clears wait_cnt to 0.
- Assert rst_n low in the cycle after a read grant: rsp_valid=0 immediately, state=SHARED, no response after release.
- With IMEM_ADDR_CHECK_EN, fetch addr 2 and addr 1024: mem_en=0, response data 0, err=1 and sticky. Without the macro: mem_addr=2 is forwarded and err=0.
